// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, load-use
// hazard detection and bubble insertion, feeding the 32-bit execute ALU.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic        id_use_imm,
  input  logic [2:0]  id_alu_ctrl,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_reg_write,
  input  logic        flush,
  input  logic [4:0]  exm_rd,
  input  logic        exm_reg_write,
  input  logic [31:0] exm_result,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic [31:0] wb_data,
  output logic        stall_id,
  output logic [31:0] alu_in_1,
  output logic [31:0] alu_in_2,
  output logic [2:0]  alu_ctrl,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write
);

  logic        valid_q, valid_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] rs1Data_q, rs1Data_d;
  logic [31:0] rs2Data_q, rs2Data_d;
  logic [31:0] imm_q, imm_d;
  logic        useImm_q, useImm_d;
  logic [2:0]  aluCtrl_q, aluCtrl_d;
  logic        memRead_q, memRead_d;
  logic        memWrite_q, memWrite_d;
  logic        regWrite_q, regWrite_d;

  logic        bubble;
  logic [31:0] fwd1;
  logic [31:0] fwd2;
  logic [31:0] operand2;

  // Load-use hazard: a load in EX whose destination the ID instruction reads.
  always_comb begin
    stall_id = id_valid & valid_q & memRead_q & (rd_q != 5'd0) &
               ((rd_q == id_rs1) | ((rd_q == id_rs2) & ~id_use_imm));
    bubble   = stall_id | flush;
  end

  // Next EX contents: capture ID, or an all-zero bubble on stall or flush.
  always_comb begin
    valid_d    = id_valid;
    rs1_d      = id_rs1;
    rs2_d      = id_rs2;
    rd_d       = id_rd;
    rs1Data_d  = id_rs1_data;
    rs2Data_d  = id_rs2_data;
    imm_d      = id_imm;
    useImm_d   = id_use_imm;
    aluCtrl_d  = id_alu_ctrl;
    memRead_d  = id_mem_read;
    memWrite_d = id_mem_write;
    regWrite_d = id_reg_write;
    if (bubble) begin
      valid_d    = 1'b0;
      rs1_d      = 5'd0;
      rs2_d      = 5'd0;
      rd_d       = 5'd0;
      rs1Data_d  = 32'd0;
      rs2Data_d  = 32'd0;
      imm_d      = 32'd0;
      useImm_d   = 1'b0;
      aluCtrl_d  = 3'd0;
      memRead_d  = 1'b0;
      memWrite_d = 1'b0;
      regWrite_d = 1'b0;
    end
  end

  // EX registers; reset discards whatever instruction is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      rd_q       <= 5'd0;
      rs1Data_q  <= 32'd0;
      rs2Data_q  <= 32'd0;
      imm_q      <= 32'd0;
      useImm_q   <= 1'b0;
      aluCtrl_q  <= 3'd0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      regWrite_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1Data_q  <= rs1Data_d;
      rs2Data_q  <= rs2Data_d;
      imm_q      <= imm_d;
      useImm_q   <= useImm_d;
      aluCtrl_q  <= aluCtrl_d;
      memRead_q  <= memRead_d;
      memWrite_q <= memWrite_d;
      regWrite_q <= regWrite_d;
    end
  end

  // Forwarding: EX/MEM beats MEM/WB, and x0 is never forwarded.
  always_comb begin
    if (exm_reg_write && (exm_rd != 5'd0) && (exm_rd == rs1_q)) begin
      fwd1 = exm_result;
    end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs1_q)) begin
      fwd1 = wb_data;
    end else begin
      fwd1 = rs1Data_q;
    end
    if (exm_reg_write && (exm_rd != 5'd0) && (exm_rd == rs2_q)) begin
      fwd2 = exm_result;
    end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs2_q)) begin
      fwd2 = wb_data;
    end else begin
      fwd2 = rs2Data_q;
    end
  end

  // Operand select; shift ops only see the low five bits of the amount.
  always_comb begin
    operand2 = useImm_q ? imm_q : fwd2;
    if ((aluCtrl_q == 3'b101) || (aluCtrl_q == 3'b110) || (aluCtrl_q == 3'b111)) begin
      alu_in_2 = {27'd0, operand2[4:0]};
    end else begin
      alu_in_2 = operand2;
    end
  end

  assign alu_in_1      = fwd1;
  assign ex_store_data = fwd2;
  assign alu_ctrl      = aluCtrl_q;
  assign ex_rd         = rd_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = regWrite_q;
  assign ex_mem_read   = memRead_q;
  assign ex_mem_write  = memWrite_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios followed by randomized
// instruction streams checked against an instruction-level reference model.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic        id_use_imm;
  logic [2:0]  id_alu_ctrl;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_reg_write;
  logic        flush;
  logic [4:0]  exm_rd;
  logic        exm_reg_write;
  logic [31:0] exm_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        stall_id;
  logic [31:0] alu_in_1;
  logic [31:0] alu_in_2;
  logic [2:0]  alu_ctrl;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;

  int testsRun;
  int testsFailed;

  // One instruction as the execute stage sees it.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        useImm;
    logic [2:0]  op;
    logic        memRead;
    logic        memWrite;
    logic        regWrite;
  } exInst_t;

  exInst_t inEx;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_ctrl(id_alu_ctrl), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .flush(flush),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .stall_id(stall_id), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_ctrl(alu_ctrl),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Value a source register holds as seen from EX, given later stages in flight.
  function automatic logic [31:0] regValue(input logic [4:0] idx, input logic [31:0] rfVal);
    if (idx == 5'd0) return rfVal;
    if (exm_reg_write && exm_rd == idx) return exm_result;
    if (wb_reg_write && wb_rd == idx) return wb_data;
    return rfVal;
  endfunction

  function automatic logic modelStall();
    logic readsRd;
    readsRd = (inEx.rd == id_rs1) || (!id_use_imm && inEx.rd == id_rs2);
    return id_valid && inEx.valid && inEx.memRead && inEx.rd != 5'd0 && readsRd;
  endfunction

  function automatic logic [31:0] modelAlu2();
    logic [31:0] amount;
    amount = inEx.useImm ? inEx.imm : regValue(inEx.rs2, inEx.d2);
    if (inEx.op >= 3'd5) return amount % 32;
    return amount;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".stall_id"}, 32'(stall_id), 32'(modelStall()));
    checkOutput({tag, ".alu_in_1"}, alu_in_1, regValue(inEx.rs1, inEx.d1));
    checkOutput({tag, ".alu_in_2"}, alu_in_2, modelAlu2());
    checkOutput({tag, ".store_data"}, ex_store_data, regValue(inEx.rs2, inEx.d2));
    checkOutput({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'(inEx.op));
    checkOutput({tag, ".ex_rd"}, 32'(ex_rd), 32'(inEx.rd));
    checkOutput({tag, ".ex_valid"}, 32'(ex_valid), 32'(inEx.valid));
    checkOutput({tag, ".ex_reg_write"}, 32'(ex_reg_write), 32'(inEx.regWrite));
    checkOutput({tag, ".ex_mem_read"}, 32'(ex_mem_read), 32'(inEx.memRead));
    checkOutput({tag, ".ex_mem_write"}, 32'(ex_mem_write), 32'(inEx.memWrite));
  endtask

  // Advance one clock edge: the model takes the ID instruction or a bubble.
  task automatic clockEdge();
    if (modelStall() || flush) begin
      inEx = '0;
    end else begin
      inEx.valid    = id_valid;
      inEx.rs1      = id_rs1;
      inEx.rs2      = id_rs2;
      inEx.rd       = id_rd;
      inEx.d1       = id_rs1_data;
      inEx.d2       = id_rs2_data;
      inEx.imm      = id_imm;
      inEx.useImm   = id_use_imm;
      inEx.op       = id_alu_ctrl;
      inEx.memRead  = id_mem_read;
      inEx.memWrite = id_mem_write;
      inEx.regWrite = id_reg_write;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm, input logic useImm, input logic [2:0] op,
                               input logic mr, input logic mw, input logic rw, input logic fl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_use_imm = useImm;
    id_alu_ctrl = op; id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
    flush = fl;
  endtask

  task automatic noForwarding();
    exm_rd = 5'd0; exm_reg_write = 1'b0; exm_result = 32'd0;
    wb_rd = 5'd0; wb_reg_write = 1'b0; wb_data = 32'd0;
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    inEx = '0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    noForwarding();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkAll("reset");

    // Plain pass: 5 - 3 with no forwarding.
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd3, 32'd0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
    clockEdge();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("pass.alu_in_1", alu_in_1, 32'd5);
    checkOutput("pass.alu_in_2", alu_in_2, 32'd3);
    checkOutput("pass.ex_valid", 32'(ex_valid), 32'd1);
    checkAll("pass");

    // Forward priority on rs1 = 7.
    applyStimulus(1'b1, 5'd7, 5'd0, 5'd4, 32'h99, 32'd0, 32'd0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    clockEdge();
    exm_rd = 5'd7; exm_reg_write = 1'b1; exm_result = 32'h11;
    wb_rd = 5'd7; wb_reg_write = 1'b1; wb_data = 32'h22;
    #1;
    checkOutput("fwd.exm_wins", alu_in_1, 32'h11);
    exm_reg_write = 1'b0;
    #1;
    checkOutput("fwd.wb", alu_in_1, 32'h22);
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd4, 32'h55, 32'd0, 32'd0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    clockEdge();
    exm_rd = 5'd0; exm_reg_write = 1'b1; wb_rd = 5'd0; wb_reg_write = 1'b1;
    #1;
    checkOutput("fwd.x0", alu_in_1, 32'h55);
    noForwarding();

    // Load-use on rs2 = 5.
    applyStimulus(1'b1, 5'd1, 5'd0, 5'd5, 32'd0, 32'd0, 32'd8, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    clockEdge();
    applyStimulus(1'b1, 5'd1, 5'd5, 5'd6, 32'd1, 32'd2, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("loaduse.stall", 32'(stall_id), 32'd1);
    clockEdge();
    checkOutput("loaduse.bubble", 32'(ex_valid), 32'd0);
    checkAll("loaduse");
    applyStimulus(1'b1, 5'd1, 5'd0, 5'd5, 32'd0, 32'd0, 32'd8, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    clockEdge();
    applyStimulus(1'b1, 5'd3, 5'd5, 5'd6, 32'd1, 32'd2, 32'd4, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("loaduse.imm_nostall", 32'(stall_id), 32'd0);

    // Shift masking.
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 32'd9, 32'h123, 32'd0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0);
    clockEdge();
    checkOutput("shift.sll", alu_in_2, 32'h3);
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 32'd9, 32'h123, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    clockEdge();
    checkOutput("shift.add", alu_in_2, 32'h123);

    // Flush of a valid store.
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd0, 32'd9, 32'd7, 32'd4, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
    clockEdge();
    checkOutput("flush.ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("flush.ex_mem_write", 32'(ex_mem_write), 32'd0);
    checkOutput("flush.ex_reg_write", 32'(ex_reg_write), 32'd0);

    // Asynchronous reset mid-cycle with a valid instruction in EX.
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 32'd9, 32'd7, 32'd4, 1'b1, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0);
    clockEdge();
    applyStimulus(1'b1, 5'd5, 5'd2, 5'd6, 32'd1, 32'd2, 32'd0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset.ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("areset.alu_ctrl", 32'(alu_ctrl), 32'd0);
    checkOutput("areset.stall_id", 32'(stall_id), 32'd0);
    inEx = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkAll("postreset");
    clockEdge();
    checkAll("postreset.capture");

    // Randomized instruction stream with random in-flight later stages.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 1'($urandom),
                    3'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                    1'($urandom), $urandom_range(0, 7) == 0);
      exm_rd = 5'($urandom_range(0, 7)); exm_reg_write = 1'($urandom); exm_result = $urandom;
      wb_rd = 5'($urandom_range(0, 7)); wb_reg_write = 1'($urandom); wb_data = $urandom;
      #1;
      checkAll("random");
      clockEdge();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
